// File: rtl/sc_stream_evaluator.sv
// Stochastic-computing evaluation engine: LFSR source, per-channel SNGs, feedback delay line and a ones counter.
// Optional signed bipolar result output is enabled by defining SC_EVAL_BIPOLAR_EN.
module sc_stream_evaluator #(
    parameter int WIDTH       = 8,
    parameter int NUM_IN      = 3,
    parameter int LEN_W       = 16,
    parameter int DELAY_DEPTH = 3,
    parameter int ROT_STEP    = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [WIDTH-1:0]        seed,
    input  logic [NUM_IN*WIDTH-1:0] value,
    input  logic [LEN_W-1:0]        stream_len,
    output logic [NUM_IN-1:0]       sn_bits,
    input  logic                    sc_bit,
    input  logic [DELAY_DEPTH-1:0]  fb_in,
    output logic [DELAY_DEPTH-1:0]  fb_out,
    output logic                    busy,
    output logic                    done,
    output logic [LEN_W-1:0]        ones_count
`ifdef SC_EVAL_BIPOLAR_EN
    ,
    output logic signed [LEN_W:0]   bipolar_val
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [WIDTH-1:0]          lfsr_q, lfsr_d;
    logic [NUM_IN*WIDTH-1:0]   value_q, value_d;
    logic [LEN_W-1:0]          remain_q, remain_d;
    logic [LEN_W-1:0]          ones_q, ones_d;
    logic [DELAY_DEPTH-1:0]    fb_q, fb_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      lfsr_fb;

    // Maximal-length feedback taps; only the branch for the chosen WIDTH is elaborated.
    if (WIDTH == 4) begin : g_taps4
        assign lfsr_fb = lfsr_q[3] ^ lfsr_q[2];
    end else if (WIDTH == 6) begin : g_taps6
        assign lfsr_fb = lfsr_q[5] ^ lfsr_q[4];
    end else if (WIDTH == 8) begin : g_taps8
        assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    end else if (WIDTH == 10) begin : g_taps10
        assign lfsr_fb = lfsr_q[9] ^ lfsr_q[6];
    end else if (WIDTH == 12) begin : g_taps12
        assign lfsr_fb = lfsr_q[11] ^ lfsr_q[10] ^ lfsr_q[9] ^ lfsr_q[3];
    end else if (WIDTH == 16) begin : g_taps16
        assign lfsr_fb = lfsr_q[15] ^ lfsr_q[14] ^ lfsr_q[12] ^ lfsr_q[3];
    end else begin : g_bad_width
        $error("sc_stream_evaluator: unsupported WIDTH %0d", WIDTH);
        assign lfsr_fb = 1'b0;
    end

    // Each channel compares against a rotated view of the shared LFSR so channels stay decorrelated.
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_sng
        localparam int ROT = (gi * ROT_STEP) % WIDTH;
        logic [WIDTH-1:0] rng;
        if (ROT == 0) begin : g_norot
            assign rng = lfsr_q;
        end else begin : g_rot
            assign rng = {lfsr_q[WIDTH-1-ROT:0], lfsr_q[WIDTH-1 -: ROT]};
        end
        assign sn_bits[gi] = (state_q == ST_RUN) && (rng <= value_q[gi*WIDTH +: WIDTH]);
    end

`ifdef SC_EVAL_BIPOLAR_EN
    logic [LEN_W-1:0]        len_q, len_d;
    logic signed [LEN_W:0]   bip_q, bip_d;
    logic [LEN_W-1:0]        len_sel;
`endif

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        value_d  = value_q;
        remain_d = remain_q;
        ones_d   = ones_q;
        fb_d     = fb_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    value_d  = value;
                    remain_d = stream_len;
                    lfsr_d   = (seed == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : seed;
                    ones_d   = '0;
                    fb_d     = '0;
                    state_d  = (stream_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                ones_d   = ones_q + LEN_W'(sc_bit);
                fb_d     = fb_in;
                lfsr_d   = {lfsr_q[WIDTH-2:0], lfsr_fb};
                remain_d = remain_q - LEN_W'(1);
                if (remain_q == LEN_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

`ifdef SC_EVAL_BIPOLAR_EN
    // A zero-length run enters DONE straight from IDLE, before len_q has been loaded.
    always_comb begin
        len_d   = (state_q == ST_IDLE && start) ? stream_len : len_q;
        len_sel = (state_q == ST_IDLE) ? stream_len : len_q;
        bip_d   = bip_q;
        if (state_d == ST_DONE && state_q != ST_DONE) begin
            bip_d = $signed({ones_d, 1'b0}) - $signed({1'b0, len_sel});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q <= '0;
            bip_q <= '0;
        end else begin
            len_q <= len_d;
            bip_q <= bip_d;
        end
    end

    assign bipolar_val = bip_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            lfsr_q   <= {{(WIDTH-1){1'b0}}, 1'b1};
            value_q  <= '0;
            remain_q <= '0;
            ones_q   <= '0;
            fb_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            value_q  <= value_d;
            remain_q <= remain_d;
            ones_q   <= ones_d;
            fb_q     <= fb_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign fb_out     = fb_q;
    assign ones_count = ones_q;

endmodule

// File: tb/tb_sc_stream_evaluator.sv
// Self-checking bench for sc_stream_evaluator (WIDTH=8): vector table with a scoreboard plus
// hand-written sequences for abort, ignored start and feedback delay.
module tb_sc_stream_evaluator;

    localparam int W  = 8;
    localparam int N  = 3;
    localparam int LW = 16;
    localparam int DD = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [W-1:0]    seed;
    logic [N*W-1:0]  value;
    logic [LW-1:0]   stream_len;
    logic [N-1:0]    sn_bits;
    logic            sc_bit;
    logic [DD-1:0]   fb_in;
    logic [DD-1:0]   fb_out;
    logic            busy;
    logic            done;
    logic [LW-1:0]   ones_count;
`ifdef SC_EVAL_BIPOLAR_EN
    logic signed [LW:0] bipolar_val;
`endif

    int   checks = 0;
    int   errors = 0;
    int   sel = 0;
    logic loop_en = 1'b1;
    logic sc_force = 1'b0;
    logic [LW-1:0] exp_q[$];

    assign sc_bit = loop_en ? sn_bits[sel] : sc_force;

    sc_stream_evaluator dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .seed       (seed),
        .value      (value),
        .stream_len (stream_len),
        .sn_bits    (sn_bits),
        .sc_bit     (sc_bit),
        .fb_in      (fb_in),
        .fb_out     (fb_out),
        .busy       (busy),
        .done       (done),
        .ones_count (ones_count)
`ifdef SC_EVAL_BIPOLAR_EN
        ,
        .bipolar_val(bipolar_val)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  seed;
        logic [7:0]  v0;
        logic [7:0]  v1;
        logic [7:0]  v2;
        logic [15:0] len;
        int          chan;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[11];
    int   sigs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic [7:0] step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] s, input int r);
        logic [15:0] d;
        d = {s, s} << r;
        return d[15:8];
    endfunction

    function automatic logic [15:0] model_count(input logic [7:0] sd, input logic [7:0] v,
                                                input int rot, input int len);
        logic [7:0]  s;
        logic [15:0] c;
        s = (sd == 8'd0) ? 8'd1 : sd;
        c = '0;
        for (int i = 0; i < len; i++) begin
            if (rotl(s, rot) <= v) c++;
            s = step(s);
        end
        return c;
    endfunction

    // Runs one evaluation with sc_bit looped from sn_bits[v.chan]; optional start pulse mid-run.
    task automatic run_vec(input int idx, input vec_t v, input int pulse_at, output int sig);
        logic [7:0]   s;
        logic [N*W-1:0] vals;
        logic [N-1:0] exp_sn;
        logic [15:0]  exp_ones;
        int cyc, busy_n, done_n, done_at, mism;
        vals = {v.v2, v.v1, v.v0};
        s = (v.seed == 8'd0) ? 8'd1 : v.seed;
        sig = 0; busy_n = 0; done_n = 0; done_at = -1; mism = 0;
        exp_ones = v.exp;
        sel = v.chan;
        loop_en = 1'b1;
        @(negedge clk);
        seed = v.seed; value = vals; stream_len = v.len; start = 1'b1;
        exp_q.push_back(v.exp);
        @(negedge clk);
        start = 1'b0; seed = ~v.seed; value = ~vals; stream_len = 16'd9;
        cyc = 1;
        while (cyc <= int'(v.len) + 3) begin
            if (busy) begin
                busy_n++;
                for (int k = 0; k < N; k++)
                    exp_sn[k] = (rotl(s, (k * 3) % 8) <= vals[k*8 +: 8]);
                if (sn_bits !== exp_sn) mism++;
                sig = sig * 31 + int'(sn_bits);
                s = step(s);
            end else if (sn_bits !== '0) begin
                mism++;
            end
            if (done) begin
                done_n++;
                if (done_at < 0) begin
                    done_at = cyc;
                    if (exp_q.size() > 0) exp_ones = exp_q.pop_front();
                    check($sformatf("ones_v%0d", idx), 32'(ones_count), 32'(exp_ones));
`ifdef SC_EVAL_BIPOLAR_EN
                    check($sformatf("bipolar_v%0d", idx), 32'(bipolar_val),
                          32'(2 * int'(exp_ones) - int'(v.len)));
`endif
                    $display("vec %0d seed %02h len %0d chan %0d ones %0d done_cycle %0d",
                             idx, v.seed, v.len, v.chan, ones_count, cyc);
                end
            end
            if (cyc == pulse_at) begin
                start = 1'b1; stream_len = 16'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (done_at < 0) begin
            check($sformatf("done_seen_v%0d", idx), 32'd0, 32'd1);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        check($sformatf("busy_cycles_v%0d", idx), 32'(busy_n), 32'(v.len));
        check($sformatf("done_cycle_v%0d", idx), 32'(done_at), 32'(int'(v.len) + 1));
        check($sformatf("done_pulses_v%0d", idx), 32'(done_n), 32'd1);
        check($sformatf("sn_trace_v%0d", idx), 32'(mism), 32'd0);
    endtask

    initial begin
        int dummy_sig;
        int done_n;
        int seen;
        rst = 1'b1; start = 1'b0; seed = '0; value = '0; stream_len = '0; fb_in = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sn", 32'(sn_bits), 32'd0);
        check("rst_fb", 32'(fb_out), 32'd0);
        check("rst_ones", 32'(ones_count), 32'd0);
        rst = 1'b0;

        vecs[0]  = '{8'h01, 8'd255, 8'd0,   8'd0,   16'd255, 0, 16'd255};
        vecs[1]  = '{8'h01, 8'd128, 8'd0,   8'd0,   16'd255, 0, 16'd128};
        vecs[2]  = '{8'h5A, 8'd7,   8'd0,   8'd128, 16'd255, 2, 16'd128};
        vecs[3]  = '{8'h01, 8'd0,   8'd0,   8'd0,   16'd255, 0, 16'd0};
        vecs[4]  = '{8'h01, 8'h40,  8'h80,  8'd0,   16'd0,   0, 16'd0};
        vecs[5]  = '{8'h33, 8'd0,   8'd100, 8'd0,   16'd37,  1, model_count(8'h33, 8'd100, 3, 37)};
        vecs[6]  = '{8'h00, 8'd77,  8'd30,  8'd200, 16'd255, 0, 16'd77};
        vecs[7]  = '{8'h01, 8'd77,  8'd30,  8'd200, 16'd255, 0, 16'd77};
        vecs[8]  = '{8'hFF, 8'd0,   8'd200, 8'd0,   16'd255, 1, 16'd200};
        vecs[9]  = '{8'h03, 8'd192, 8'd0,   8'd0,   16'd255, 0, 16'd192};
        vecs[10] = '{8'h07, 8'd150, 8'd0,   8'd0,   16'd20,  0, model_count(8'h07, 8'd150, 0, 20)};

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i], -1, sigs[i]);
        check("seed0_vs_seed1_trace", 32'(sigs[6] - sigs[7]), 32'd0);

        // Start pulsed during RUN must not disturb the run.
        run_vec(10, vecs[10], 5, dummy_sig);

        // Reset during RUN aborts with no done pulse.
        sel = 0; loop_en = 1'b1;
        @(negedge clk);
        seed = 8'h01; value = {8'd0, 8'd0, 8'd255}; stream_len = 16'd255; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (99) @(negedge clk);
        check("pre_abort_ones", 32'(ones_count), 32'd99);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ones", 32'(ones_count), 32'd0);
        check("abort_fb", 32'(fb_out), 32'd0);
        done_n = 0;
        for (int c = 0; c < 300; c++) begin
            if (done || busy) done_n++;
            @(negedge clk);
        end
        check("abort_no_done", 32'(done_n), 32'd0);
        $display("abort sequence ones_after %0d", ones_count);

        // Feedback delay line: fb_out follows fb_in one cycle later during RUN, holds in IDLE.
        loop_en = 1'b0; sc_force = 1'b1;
        @(negedge clk);
        seed = 8'h21; value = '0; stream_len = 16'd10; start = 1'b1; fb_in = 3'b111;
        exp_q.push_back(16'd10);
        @(negedge clk);
        start = 1'b0;
        check("fb_clear_on_start", 32'(fb_out), 32'd0);
        fb_in = 3'b101;
        @(negedge clk);
        check("fb_101", 32'(fb_out), 32'b101);
        fb_in = 3'b010;
        @(negedge clk);
        check("fb_010", 32'(fb_out), 32'b010);
        fb_in = 3'b110;
        seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                check("fb_run_ones", 32'(ones_count), 32'(exp_q.pop_front()));
            end
        end
        if (seen == 0) begin
            check("fb_run_done_seen", 32'd0, 32'd1);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        fb_in = 3'b001;
        repeat (3) @(negedge clk);
        check("fb_hold_idle", 32'(fb_out), 32'b110);
        check("ones_hold_idle", 32'(ones_count), 32'd10);
        $display("feedback sequence fb_out %03b ones %0d", fb_out, ones_count);

        // A fresh start clears fb_out again.
        @(negedge clk);
        stream_len = 16'd2; start = 1'b1; fb_in = 3'b000;
        @(negedge clk);
        start = 1'b0;
        check("fb_clear_second", 32'(fb_out), 32'd0);
        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sc_stream_evaluator.md
Name: sc_stream_evaluator

Overview:
- Parametrised stochastic-computing evaluation engine; successor to the fixed 8-bit single-stream circuit harness.
- Internalises three things: the LFSR random source, the per-channel SNG comparators, and the feedback delay registers.
- Counts ones in the circuit-under-test output stream over a programmable length, with a start/done handshake.
- Sits between the generated combinational SC netlist and the evaluation controller.

Parameters:
- WIDTH, 8, LFSR/comparator width; legal values 4, 6, 8, 10, 12, 16; any other value is an elaboration error.
- NUM_IN, 3, number of stochastic input channels.
- LEN_W, 16, width of the stream-length and ones counters.
- DELAY_DEPTH, 3, number of feedback delay bits for the circuit under test.
- ROT_STEP, 3, per-channel LFSR rotation step, for decorrelation.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin evaluation; honoured only in IDLE.
- seed  in  WIDTH  LFSR seed, sampled on start.
- value  in  NUM_IN*WIDTH  binary operands; channel k occupies bits [k*WIDTH +: WIDTH]; sampled on start.
- stream_len  in  LEN_W  number of samples, sampled on start.
- sn_bits  out  NUM_IN  stochastic bits to the circuit under test.
- sc_bit  in  1  circuit-under-test output bit.
- fb_in  in  DELAY_DEPTH  next-state bits from the circuit under test.
- fb_out  out  DELAY_DEPTH  delayed state bits to the circuit under test.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle completion pulse.
- ones_count  out  LEN_W  ones counted in the last run.

Behaviour:
- Reset: rst has priority over start. State goes to IDLE, LFSR to 1, all counters to 0, busy=0, done=0, sn_bits=0, fb_out=0, ones_count=0.
- Reset during RUN aborts the run with no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 (cycle 0):
  - Latch value and stream_len.
  - Load LFSR with seed; seed 0 is replaced by 1.
  - Clear ones_count and fb_out.
  - stream_len==0: go to DONE.
  - Otherwise: go to RUN.
- RUN: busy=1 during cycles 1..stream_len. On each RUN edge:
  - ones_count += sc_bit;
  - fb_out <= fb_in;
  - LFSR advances one step;
  - remaining count decrements.
  - After the stream_len-th sample, go to DONE.
- DONE: done=1 for exactly one cycle (cycle stream_len+1; cycle 1 when stream_len=0), then IDLE.
- ones_count holds its value until the next accepted start. start during RUN or DONE is ignored.
- LFSR: Fibonacci, shift left, feedback = XOR of taps, maximal length (period 2^WIDTH-1, never 0). Taps:
  - 4: 4,3
  - 6: 6,5
  - 8: 8,6,5,4
  - 10: 10,7
  - 12: 12,11,10,4
  - 16: 16,15,13,4
- SNG: rng_k = LFSR state rotated left by (k*ROT_STEP mod WIDTH); sn_bits[k] = (rng_k <= value_k).
  - Combinational from registered LFSR and latched value.
  - Forced to 0 outside RUN.
  - Over one full period, the ones in sn_bits[k] = value_k exactly (value 0 gives all zeros; 2^WIDTH-1 gives all ones).
- sc_bit is sampled at the same edge that advances the LFSR: zero-latency combinational path through the circuit under test.
- ones_count ≤ stream_len, so it never overflows.
- fb_out holds its value in IDLE and DONE.

Optional Feature:
- Macro: SC_EVAL_BIPOLAR_EN.
- Defined: adds port bipolar_val, out, LEN_W+1 bits, signed.
  - Registered on entry to DONE as 2*ones_count - stream_len.
  - Reset to 0; held until the next start.
- Undefined: port absent; unipolar count only.

Test Plan:
- WIDTH=8, seed=1, value0=255, stream_len=255, sc_bit=sn_bits[0] -> sn_bits[0]=1 every RUN cycle; busy high cycles 1..255; done pulse in cycle 256; ones_count=255.
- value0=128, stream_len=255, sc_bit=sn_bits[0] -> ones_count=128. Repeat on channel 2 (rotated) -> 128. value0=0 -> 0.
- stream_len=0, start in cycle 0 -> busy never high; done in cycle 1; ones_count=0.
- seed=0 vs seed=1, same value -> identical sn_bits trace and identical ones_count.
- rst asserted at sample 100 of 255 -> next cycle busy=0, ones_count=0, fb_out=0, no done pulse. start pulsed during RUN -> ignored, and the run length is unchanged.
- fb_in driven with 3'b101 then 3'b010 -> fb_out shows each one cycle later. With SC_EVAL_BIPOLAR_EN, value0=192 over 255 -> ones_count=192, bipolar_val=+129.
